jtdd_objdma: RTL and testbench
==============================

# jtdd_objdma

Object-table DMA sequencer for the main CPU board. It runs once per frame, at the start of vertical blanking. It requests the 6809 bus, copies the 512-byte object table from the top of the 8 kB work RAM into the object line-engine buffer, and then releases the bus. It drives the `bus_req`/`bus_ack` handshake and the `blcnten`/`obj_AB` RAM-address override on the CPU board. It feeds the object renderer's private buffer.

## Interface
Parameters:
- `AW`, 9, object table address width (table length 2^AW bytes).
- `RD_LAT`, 1, work-RAM read latency in `cen` ticks (1..3).

Ports:
- `clk`  in  1  system clock.
- `nRESET`  in  1  reset: asynchronous, active-low.
- `cen`  in  1  clock enable (6 MHz); all state advances only on `cen`.
- `LVBL`  in  1  active-low vertical blank.
- `dma_en`  in  1  high enables per-frame transfer; sampled at start of vertical blank (the `LVBL` falling edge).
- `bus_ack`  in  1  CPU bus granted (BA&&BS).
- `bus_req`  out  1  request CPU halt / bus release.
- `blcnten`  out  1  RAM address override; high only while this block owns the RAM.
- `obj_AB`  out  AW  work-RAM read address (board maps it to 0x1E00+).
- `ram_dout`  in  8  work-RAM read data.
- `buf_we`  out  1  object buffer write strobe, one `cen` tick per byte.
- `buf_addr`  out  AW  object buffer write address.
- `buf_din`  out  8  object buffer write data.
- `busy`  out  1  high from request until release.
- `done`  out  1  one-`cen`-tick pulse at end of transfer.
- `late`  out  1  sticky; set if vblank ends (`LVBL` rises) while `busy`; cleared by the next start.

## Operation
FSM states, with transitions evaluated on `cen`:
- **IDLE**
  - Detect the `LVBL` falling edge using a registered `last_LVBL`.
  - If `dma_en` is high at the edge, set `bus_req`, clear `late`, go to REQ.
- **REQ**
  - Hold `bus_req` high and wait for `bus_ack`.
  - There is no timeout. The CPU must grant.
- **COPY**
  - Entered on the first `bus_ack` tick.
  - `blcnten`=1. `rd_addr` increments every tick `bus_ack` is high, while `rd_addr` < 2^AW.
  - After RD_LAT ticks, `buf_we`=1 with `buf_addr`=`wr_addr` and `buf_din`=`ram_dout`. `wr_addr` then increments.
- **DRAIN**
  - Entered after the last read issues.
  - Keep writing until `wr_addr` wraps to 0, i.e. 2^AW bytes written.
- **RELEASE**
  - Drop `blcnten`, then `bus_req` one tick later.
  - Pulse `done`, then return to IDLE.

Rules:
- `obj_AB` = `rd_addr`. Counters are AW+1 bits wide; bit AW set marks the end of the transfer.
- If `bus_ack` drops during COPY or DRAIN:
  - Stop immediately: `buf_we`=0, `blcnten`=0.
  - Discard in-flight reads: `rd_addr` <= `wr_addr`.
  - Return to REQ.
- Each byte is written exactly once, in ascending order.
- An `LVBL` falling edge while not in IDLE is ignored. There is no re-trigger.
- An `LVBL` rising edge while `busy` sets `late`. The transfer still completes.
- If `dma_en` is low at the edge, nothing happens for that frame.

## Timing
- Reset values: `bus_req`=0, `blcnten`=0, `obj_AB`=0, `buf_we`=0, `buf_addr`=0, `buf_din`=0, `busy`=0, `done`=0, `late`=0, FSM in IDLE, `last_LVBL`=1.
- `bus_req` rises on the first `cen` tick after the edge is seen.
- `busy` rises with `bus_req` and falls with `bus_req`.
- Uninterrupted transfer length, from grant to `done`: 2^AW + RD_LAT + 2 ticks.
- Aborting on reset mid-transfer: all outputs return to their reset values asynchronously, with no `done` pulse.
- `blcnten` is never high when `bus_ack` is low, including the tick on which `bus_ack` falls (combinational gate).

## Structure
- Constants in `jtdd_pkg`: the state enum (IDLE, REQ, COPY, DRAIN, RELEASE) and the `OBJ_BASE` constant 13'h1E00, used for documentation and the bench model.
- Single module. No sub-module needed; edge detection is inline.

## Test plan
- **Normal frame:** `dma_en`=1, `LVBL` 1->0, `bus_ack` granted 3 ticks later, RAM preloaded with `obj_AB` XOR 8'h5A.
  - Exactly 512 `buf_we` pulses.
  - `buf_din` equals `buf_addr` XOR 8'h5A.
  - `done` occurs 515 ticks (RD_LAT=1) after the grant.
- **Grant loss:** drop `bus_ack` for 10 ticks at byte 200.
  - No writes during the gap.
  - Bytes 199..201 are written once each, in order.
  - Total writes = 512.
- **Disabled:** `dma_en`=0 at the edge.
  - `bus_req` stays 0 for the whole frame.
  - Zero writes.
- **Late vblank:** `LVBL` rises at byte 100.
  - `late`=1 and stays set until the next start.
  - The transfer still completes with 512 writes.
- **Reset mid-COPY:** `nRESET` pulsed low at byte 300.
  - All outputs return to their reset values immediately.
  - The next `LVBL` edge starts a full transfer from address 0.
- **RD_LAT=3 build:** the normal-frame check passes with `done` occurring 517 ticks after the grant.

Source files
------------

// File: rtl/jtdd_pkg.sv
// Shared types and constants for the object-table DMA sequencer.
package jtdd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COPY,
        DRAIN,
        RELEASE
    } objdma_state_t;

    // Work-RAM byte address seen by the board when obj_AB == 0.
    localparam logic [12:0] OBJ_BASE = 13'h1E00;

endpackage

// File: rtl/jtdd_objdma.sv
// Object-table DMA: once per frame, borrows the 6809 bus and copies the 2^AW-byte
// object table from work RAM into the object line-engine buffer.
module jtdd_objdma
    import jtdd_pkg::*;
#(
    parameter int AW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          cen,
    input  logic          LVBL,
    input  logic          dma_en,
    input  logic          bus_ack,
    output logic          bus_req,
    output logic          blcnten,
    output logic [AW-1:0] obj_AB,
    input  logic [7:0]    ram_dout,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_din,
    output logic          busy,
    output logic          done,
    output logic          late
);

    objdma_state_t     state_q, state_d;
    logic [AW:0]       rd_q, rd_d;
    logic [AW:0]       wr_q, wr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              bus_req_q, bus_req_d;
    logic              done_q, done_d;
    logic              late_q, late_d;
    logic              last_lvbl_q;
    logic              active, issue, wr_en, lvbl_fall, lvbl_rise;

    assign active    = (state_q == COPY) || (state_q == DRAIN);
    assign lvbl_fall = last_lvbl_q & ~LVBL;
    assign lvbl_rise = ~last_lvbl_q & LVBL;

    // bus_ack gates the RAM override directly so it lets go on the very tick the grant drops.
    assign issue = active & bus_ack & ~rd_q[AW];
    // vld_q[RD_LAT-1] marks that ram_dout now holds the byte addressed RD_LAT ticks ago.
    assign wr_en = active & bus_ack & vld_q[RD_LAT-1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        bus_req_d = bus_req_q;
        done_d    = 1'b0;
        late_d    = late_q;
        vld_d[0]  = issue;
        for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];

        if (issue) rd_d = rd_q + (AW+1)'(1);
        if (wr_en) wr_d = wr_q + (AW+1)'(1);
        if (lvbl_rise && bus_req_q) late_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (lvbl_fall && dma_en) begin
                    bus_req_d = 1'b1;
                    late_d    = 1'b0;
                    rd_d      = '0;
                    wr_d      = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus_ack) state_d = COPY;
            end
            COPY, DRAIN: begin
                if (!bus_ack) begin
                    // Reads still in flight are lost; restart from the first unwritten byte.
                    rd_d    = wr_q;
                    vld_d   = '0;
                    state_d = REQ;
                end else if (wr_d[AW]) begin
                    state_d = RELEASE;
                end else if (rd_d[AW]) begin
                    state_d = DRAIN;
                end
            end
            RELEASE: begin
                bus_req_d = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            wr_q        <= '0;
            vld_q       <= '0;
            bus_req_q   <= 1'b0;
            done_q      <= 1'b0;
            late_q      <= 1'b0;
            last_lvbl_q <= 1'b1;
        end else if (cen) begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            vld_q       <= vld_d;
            bus_req_q   <= bus_req_d;
            done_q      <= done_d;
            late_q      <= late_d;
            last_lvbl_q <= LVBL;
        end
    end

    assign bus_req  = bus_req_q;
    assign busy     = bus_req_q;
    assign done     = done_q;
    assign late     = late_q;
    assign blcnten  = active & bus_ack;
    assign obj_AB   = rd_q[AW-1:0];
    assign buf_we   = wr_en;
    assign buf_addr = wr_q[AW-1:0];
    assign buf_din  = wr_en ? ram_dout : 8'h00;

endmodule

// File: tb/tb_jtdd_objdma.sv
// Directed bench for jtdd_objdma: RD_LAT=1 instance for all scenarios, RD_LAT=3 instance for timing.
module tb_jtdd_objdma;
    import jtdd_pkg::*;

    localparam int AW     = 9;
    localparam int NBYTES = 1 << AW;

    logic clk = 1'b0, cen = 1'b0, nRESET = 1'b0, dma_en = 1'b0;
    logic LVBL = 1'b1, bus_ack = 1'b0, LVBL3 = 1'b1, bus_ack3 = 1'b0;
    logic clr_mon = 1'b0;

    logic          bus_req, blcnten, buf_we, busy, done, late;
    logic [AW-1:0] obj_AB, buf_addr;
    logic [7:0]    buf_din, ram_dout;
    logic          bus_req3, blcnten3, buf_we3, busy3, done3, late3;
    logic [AW-1:0] obj_AB3, buf_addr3;
    logic [7:0]    buf_din3, ram_dout3;

    int checks = 0, errors = 0;

    jtdd_objdma #(.AW(AW), .RD_LAT(1)) dut (
        .clk(clk), .nRESET(nRESET), .cen(cen), .LVBL(LVBL), .dma_en(dma_en),
        .bus_ack(bus_ack), .bus_req(bus_req), .blcnten(blcnten), .obj_AB(obj_AB),
        .ram_dout(ram_dout), .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din),
        .busy(busy), .done(done), .late(late)
    );

    jtdd_objdma #(.AW(AW), .RD_LAT(3)) dut3 (
        .clk(clk), .nRESET(nRESET), .cen(cen), .LVBL(LVBL3), .dma_en(dma_en),
        .bus_ack(bus_ack3), .bus_req(bus_req3), .blcnten(blcnten3), .obj_AB(obj_AB3),
        .ram_dout(ram_dout3), .buf_we(buf_we3), .buf_addr(buf_addr3), .buf_din(buf_din3),
        .busy(busy3), .done(done3), .late(late3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cen <= ~cen;

    // Work RAM holds (byte address low 8 bits) ^ 8'h5A across the object table.
    function automatic logic [7:0] ram_byte(input logic [AW-1:0] a);
        logic [12:0] full;
        full = OBJ_BASE + 13'(a);
        return full[7:0] ^ 8'h5A;
    endfunction

    logic [7:0] p1 = 8'h00, p3a = 8'h00, p3b = 8'h00, p3c = 8'h00;
    always @(posedge clk) begin
        if (cen) begin
            p1  <= ram_byte(obj_AB);
            p3a <= ram_byte(obj_AB3);
            p3b <= p3a;
            p3c <= p3b;
        end
    end
    assign ram_dout  = p1;
    assign ram_dout3 = p3c;

    // Monitor: samples each cen tick before its active edge and records what it saw.
    int          ticks = 0, nwr = 0, bad_wr = 0, blc_bad = 0, grant_tick = -1, done_tick = -1, done_cnt = 0;
    int          nwr3 = 0, bad3 = 0, grant3 = -1, done3_tick = -1, done3_cnt = 0;
    logic        req_seen = 1'b0;
    logic [AW:0] wr_exp = '0, wr_exp3 = '0;

    always @(negedge clk) begin
        if (cen) begin
            ticks <= ticks + 1;
            if (clr_mon) begin
                nwr <= 0; bad_wr <= 0; blc_bad <= 0; grant_tick <= -1; done_tick <= -1;
                done_cnt <= 0; req_seen <= 1'b0; wr_exp <= '0;
                nwr3 <= 0; bad3 <= 0; grant3 <= -1; done3_tick <= -1; done3_cnt <= 0; wr_exp3 <= '0;
            end else begin
                if (buf_we) begin
                    if (buf_addr !== wr_exp[AW-1:0] || buf_din !== ram_byte(buf_addr)) bad_wr <= bad_wr + 1;
                    wr_exp <= wr_exp + 1'b1;
                    nwr    <= nwr + 1;
                end
                if (blcnten && !bus_ack) blc_bad <= blc_bad + 1;
                if (bus_req && bus_ack && grant_tick < 0) grant_tick <= ticks;
                if (done) begin done_tick <= ticks; done_cnt <= done_cnt + 1; end
                if (bus_req) req_seen <= 1'b1;
                if (buf_we3) begin
                    if (buf_addr3 !== wr_exp3[AW-1:0] || buf_din3 !== ram_byte(buf_addr3)) bad3 <= bad3 + 1;
                    wr_exp3 <= wr_exp3 + 1'b1;
                    nwr3    <= nwr3 + 1;
                end
                if (blcnten3 && !bus_ack3) bad3 <= bad3 + 1;
                if (bus_req3 && bus_ack3 && grant3 < 0) grant3 <= ticks;
                if (done3) begin done3_tick <= ticks; done3_cnt <= done3_cnt + 1; end
            end
        end
    end

    // Returns just after an active edge; inputs driven now are seen on the next tick.
    task automatic tick();
        do @(negedge clk); while (cen !== 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        tick();
        clr_mon = 1'b0;
    endtask

    task automatic wait_req(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_req === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_nwr(input int target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (nwr >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
    endtask

    // Starts a frame on the RD_LAT=1 instance and grants the bus 3 ticks after the request.
    task automatic start_and_grant(input string tag);
        logic ok;
        LVBL = 1'b0;
        wait_req(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL %s_req_timeout got bus_req=%0b want 1", tag, bus_req); end
        ticks_n(3);
        bus_ack = 1'b1;
    endtask

    task automatic test_reset();
        ticks_n(2);
        checks++;
        if ({bus_req, blcnten, obj_AB, buf_we, buf_addr, buf_din, busy, done, late} !== 32'h0)
            begin errors++; $display("FAIL reset_outputs got %h want 0", {bus_req, blcnten, obj_AB, buf_we, buf_addr, buf_din, busy, done, late}); end
        nRESET = 1'b1;
        ticks_n(3);
        checks++;
        if ({bus_req3, blcnten3, obj_AB3, buf_we3, buf_addr3, buf_din3, busy3, done3, late3} !== 32'h0)
            begin errors++; $display("FAIL reset_outputs_rdlat3 got %h want 0", {bus_req3, blcnten3, obj_AB3, buf_we3, buf_addr3, buf_din3, busy3, done3, late3}); end
    endtask

    task automatic test_normal();
        logic ok;
        clear_mon();
        dma_en = 1'b1;
        start_and_grant("normal");
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy got %0b want 1", busy); end
        wait_done(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL normal_done_timeout got %0b want 1", ok); end
        ticks_n(2);
        checks++;
        if (nwr !== NBYTES) begin errors++; $display("FAIL normal_writes got %0d want %0d", nwr, NBYTES); end
        checks++;
        if (bad_wr !== 0) begin errors++; $display("FAIL normal_data_order got %0d bad want 0", bad_wr); end
        checks++;
        if (done_tick - grant_tick !== 515) begin errors++; $display("FAIL normal_latency got %0d want 515", done_tick - grant_tick); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL normal_done_pulses got %0d want 1", done_cnt); end
        checks++;
        if (blc_bad !== 0) begin errors++; $display("FAIL normal_blcnten_gate got %0d want 0", blc_bad); end
        checks++;
        if ({bus_req, busy, late} !== 3'b000) begin errors++; $display("FAIL normal_released got %b want 000", {bus_req, busy, late}); end
        bus_ack = 1'b0;
        LVBL    = 1'b1;
        ticks_n(3);
    endtask

    task automatic test_grant_loss();
        logic ok;
        int   n0;
        clear_mon();
        start_and_grant("loss");
        wait_nwr(200, ok);
        checks++;
        if (ok !== 1'b1 || nwr !== 200) begin errors++; $display("FAIL loss_reach200 got %0d want 200", nwr); end
        bus_ack = 1'b0;
        n0 = nwr;
        ticks_n(10);
        checks++;
        if (nwr !== n0) begin errors++; $display("FAIL loss_gap_writes got %0d want %0d", nwr, n0); end
        checks++;
        if ({bus_req, blcnten} !== 2'b10) begin errors++; $display("FAIL loss_gap_bus got %b want 10", {bus_req, blcnten}); end
        bus_ack = 1'b1;
        wait_done(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL loss_done_timeout got %0b want 1", ok); end
        checks++;
        if (nwr !== NBYTES) begin errors++; $display("FAIL loss_writes got %0d want %0d", nwr, NBYTES); end
        checks++;
        if (bad_wr !== 0 || blc_bad !== 0) begin errors++; $display("FAIL loss_data_order got bad=%0d blc=%0d want 0", bad_wr, blc_bad); end
        bus_ack = 1'b0;
        LVBL    = 1'b1;
        ticks_n(3);
    endtask

    task automatic test_disabled();
        clear_mon();
        dma_en  = 1'b0;
        LVBL    = 1'b0;
        ticks_n(40);
        LVBL    = 1'b1;
        ticks_n(5);
        checks++;
        if (req_seen !== 1'b0) begin errors++; $display("FAIL disabled_bus_req got %0b want 0", req_seen); end
        checks++;
        if (nwr !== 0) begin errors++; $display("FAIL disabled_writes got %0d want 0", nwr); end
        dma_en = 1'b1;
    endtask

    task automatic test_late();
        logic ok;
        clear_mon();
        start_and_grant("late");
        wait_nwr(100, ok);
        LVBL = 1'b1;
        ticks_n(2);
        checks++;
        if ({late, busy} !== 2'b11) begin errors++; $display("FAIL late_set got %b want 11", {late, busy}); end
        wait_done(ok);
        ticks_n(2);
        checks++;
        if (nwr !== NBYTES || bad_wr !== 0) begin errors++; $display("FAIL late_writes got %0d bad=%0d want %0d", nwr, bad_wr, NBYTES); end
        checks++;
        if (late !== 1'b1) begin errors++; $display("FAIL late_sticky got %0b want 1", late); end
        bus_ack = 1'b0;
        clear_mon();
        start_and_grant("late_next");
        checks++;
        if (late !== 1'b0) begin errors++; $display("FAIL late_clear_on_start got %0b want 0", late); end
        wait_done(ok);
        checks++;
        if (ok !== 1'b1 || nwr !== NBYTES) begin errors++; $display("FAIL late_next_frame got %0d want %0d", nwr, NBYTES); end
        bus_ack = 1'b0;
        LVBL    = 1'b1;
        ticks_n(3);
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   d0;
        clear_mon();
        start_and_grant("rstmid");
        wait_nwr(300, ok);
        nRESET = 1'b0;
        #1;
        checks++;
        if ({bus_req, blcnten, obj_AB, buf_we, buf_addr, buf_din, busy, done, late} !== 32'h0)
            begin errors++; $display("FAIL rstmid_outputs got %h want 0", {bus_req, blcnten, obj_AB, buf_we, buf_addr, buf_din, busy, done, late}); end
        d0      = done_cnt;
        LVBL    = 1'b1;
        bus_ack = 1'b0;
        ticks_n(3);
        nRESET  = 1'b1;
        ticks_n(3);
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL rstmid_no_done got %0d want %0d", done_cnt, d0); end
        clear_mon();
        start_and_grant("rstmid_next");
        wait_done(ok);
        checks++;
        if (ok !== 1'b1 || nwr !== NBYTES || bad_wr !== 0)
            begin errors++; $display("FAIL rstmid_full_restart got %0d bad=%0d want %0d", nwr, bad_wr, NBYTES); end
        bus_ack = 1'b0;
        LVBL    = 1'b1;
        ticks_n(3);
    endtask

    task automatic test_rdlat3();
        logic ok;
        clear_mon();
        LVBL3 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_req3 === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL rdlat3_req_timeout got %0b want 1", bus_req3); end
        ticks_n(3);
        bus_ack3 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (done3_cnt > 0) begin ok = 1'b1; break; end
        end
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL rdlat3_done_timeout got %0b want 1", ok); end
        checks++;
        if (done3_tick - grant3 !== 517) begin errors++; $display("FAIL rdlat3_latency got %0d want 517", done3_tick - grant3); end
        checks++;
        if (nwr3 !== NBYTES || bad3 !== 0) begin errors++; $display("FAIL rdlat3_writes got %0d bad=%0d want %0d", nwr3, bad3, NBYTES); end
        bus_ack3 = 1'b0;
        LVBL3    = 1'b1;
        ticks_n(3);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_grant_loss();
        test_disabled();
        test_late();
        test_reset_mid();
        test_rdlat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
